// File: rtl/aht20_target_emulator.sv
// aht20_target_emulator
// I2C target that behaves like an AHT20 humidity/temperature sensor. It
// answers status reads, the 0xBE calibration command, the 0xAC trigger,
// the 0xBA soft reset and the 7-byte measurement read, reporting the raw
// values present on hum_in/temp_in when a measurement completes.
//
// Ports:
//   clock, reset      : system clock, asynchronous active-high reset
//   scl_i, sda_i      : sampled bus lines (synchronized internally)
//   sda_o             : open-drain SDA drive, 0 pulls low, 1 releases
//   hum_in, temp_in   : 20-bit raw values captured at measurement completion
//   calibrated, busy  : status bits 3 and 7
//   cmd_err           : one-cycle pulse when a write transaction is not a known command
//
// Bus handshake: a bit is transferred on each SCL high phase; SDA is sampled
// on the detected SCL rise and sda_o only changes on the clock after a
// detected SCL fall, so the line is stable for the whole high phase.
module aht20_target_emulator #(
    parameter logic [6:0]  ADDRESS     = 7'h38,
    parameter logic [31:0] MEAS_CYCLES = 32'd8000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    input  logic [19:0] hum_in,
    input  logic [19:0] temp_in,
    output logic        calibrated,
    output logic        busy,
    output logic        cmd_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_scl_s1, r_scl_s2, r_scl_prev;
    logic        r_sda_s1, r_sda_s2, r_sda_prev;
    logic        w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_rx, r_tx;
    logic        r_ack;
    logic [3:0]  r_rd_idx;
    logic [2:0]  r_wr_cnt;
    logic [7:0]  r_wbuf [0:2];
    logic        r_wr_pending;
    logic        r_sda_o, r_calibrated, r_busy, r_cmd_err;
    logic [31:0] r_meas_cnt;
    logic [19:0] r_hum, r_temp;
    logic [7:0]  r_crc;
    logic [3:0]  w_load_idx;
    logic [7:0]  w_load_byte, w_status;
    logic        w_addr_match, w_is_cal, w_is_trig, w_is_soft, w_is_probe;

    // CRC-8, poly 0x31, init 0xFF, MSB first, over 6 bytes.
    function automatic logic [7:0] crc8_48(input logic [47:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 47; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h31;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign w_scl_rise   = r_scl_s2 & ~r_scl_prev;
    assign w_scl_fall   = ~r_scl_s2 & r_scl_prev;
    assign w_start      = r_sda_prev & ~r_sda_s2 & r_scl_s2;
    assign w_stop       = ~r_sda_prev & r_sda_s2 & r_scl_s2;
    assign w_addr_match = (r_rx[7:1] == ADDRESS);

    assign w_is_probe = (r_wr_cnt == 3'd0);
    assign w_is_cal   = (r_wr_cnt == 3'd3) && (r_wbuf[0] == 8'hBE) && (r_wbuf[1] == 8'h08) && (r_wbuf[2] == 8'h00);
    assign w_is_trig  = (r_wr_cnt == 3'd3) && (r_wbuf[0] == 8'hAC) && (r_wbuf[1] == 8'h33) && (r_wbuf[2] == 8'h00);
    assign w_is_soft  = (r_wr_cnt == 3'd1) && (r_wbuf[0] == 8'hBA);

    // Byte about to be loaded into the read shift register. The index
    // parks at 8, where every further byte reads as 0xFF.
    always_comb begin
        w_status = {r_busy, 3'b000, r_calibrated, 3'b000};
        if (r_state == S_ADDR_ACK)  w_load_idx = 4'd0;
        else if (r_rd_idx == 4'd8)  w_load_idx = 4'd8;
        else                        w_load_idx = r_rd_idx + 4'd1;
        case (w_load_idx)
            4'd0:    w_load_byte = w_status;
            4'd1:    w_load_byte = r_hum[19:12];
            4'd2:    w_load_byte = r_hum[11:4];
            4'd3:    w_load_byte = {r_hum[3:0], r_temp[19:16]};
            4'd4:    w_load_byte = r_temp[15:8];
            4'd5:    w_load_byte = r_temp[7:0];
            4'd6:    w_load_byte = r_crc;
            default: w_load_byte = 8'hFF;
        endcase
    end

    // Bit-level state: all data-phase transitions happen on the SCL fall.
    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = S_ADDR;
        end else if (w_stop) begin
            w_state_next = S_IDLE;
        end else if (w_scl_fall) begin
            case (r_state)
                S_ADDR:     if (r_bit_cnt == 4'd8) w_state_next = w_addr_match ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK: w_state_next = r_rx[0] ? S_RD_DATA : S_WR_DATA;
                S_WR_DATA:  if (r_bit_cnt == 4'd8) w_state_next = S_WR_ACK;
                S_WR_ACK:   w_state_next = S_WR_DATA;
                S_RD_DATA:  if (r_bit_cnt == 4'd8) w_state_next = S_RD_ACK;
                S_RD_ACK:   w_state_next = r_ack ? S_IGNORE : S_RD_DATA;
                default:    w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Synchronizers reset to the idle-bus level so no false START/STOP.
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_prev <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_prev <= 1'b1;
            r_bit_cnt <= 4'd0; r_rx <= 8'h00; r_tx <= 8'h00; r_ack <= 1'b1;
            r_rd_idx <= 4'd0; r_wr_cnt <= 3'd0; r_wr_pending <= 1'b0;
            r_wbuf[0] <= 8'h00; r_wbuf[1] <= 8'h00; r_wbuf[2] <= 8'h00;
            r_sda_o <= 1'b1; r_calibrated <= 1'b0; r_busy <= 1'b0; r_cmd_err <= 1'b0;
            r_meas_cnt <= 32'd0; r_hum <= 20'd0; r_temp <= 20'd0; r_crc <= 8'h00;
        end else begin
            r_scl_s1 <= scl_i; r_scl_s2 <= r_scl_s1; r_scl_prev <= r_scl_s2;
            r_sda_s1 <= sda_i; r_sda_s2 <= r_sda_s1; r_sda_prev <= r_sda_s2;
            r_cmd_err <= 1'b0;

            if (r_busy) begin
                if (r_meas_cnt == 32'd0) begin
                    r_busy <= 1'b0;
                    r_hum  <= hum_in;
                    r_temp <= temp_in;
                    r_crc  <= crc8_48({1'b0, 3'b000, r_calibrated, 3'b000, hum_in, temp_in});
                end else begin
                    r_meas_cnt <= r_meas_cnt - 32'd1;
                end
            end

            if (w_start) begin
                // A pending write survives a repeated START and is judged at STOP.
                r_sda_o   <= 1'b1;
                r_bit_cnt <= 4'd0;
            end else if (w_stop) begin
                r_sda_o      <= 1'b1;
                r_bit_cnt    <= 4'd0;
                r_wr_pending <= 1'b0;
                if (r_wr_pending) begin
                    if (w_is_cal) begin
                        r_calibrated <= 1'b1;
                    end else if (w_is_trig) begin
                        if (!r_busy) begin
                            r_busy     <= 1'b1;
                            r_meas_cnt <= MEAS_CYCLES;
                        end
                    end else if (w_is_soft) begin
                        // Placed after the countdown so it wins over a completing measurement.
                        r_calibrated <= 1'b0;
                        r_busy       <= 1'b0;
                        r_hum        <= 20'd0;
                        r_temp       <= 20'd0;
                        r_crc        <= 8'h00;
                    end else if (!w_is_probe) begin
                        r_cmd_err <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    S_ADDR, S_WR_DATA: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_rx      <= {r_rx[6:0], r_sda_s2};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= 4'd0;
                            if (r_state == S_ADDR) begin
                                r_sda_o <= w_addr_match ? 1'b0 : 1'b1;
                            end else begin
                                if (r_wr_cnt < 3'd3) r_wbuf[r_wr_cnt[1:0]] <= r_rx;
                                if (r_wr_cnt != 3'd4) r_wr_cnt <= r_wr_cnt + 3'd1;
                                r_sda_o <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (r_rx[0]) begin
                                r_rd_idx  <= 4'd0;
                                r_sda_o   <= w_load_byte[7];
                                r_tx      <= {w_load_byte[6:0], 1'b0};
                                r_bit_cnt <= 4'd1;
                            end else begin
                                r_sda_o      <= 1'b1;
                                r_bit_cnt    <= 4'd0;
                                r_wr_cnt     <= 3'd0;
                                r_wr_pending <= 1'b1;
                            end
                        end
                    end
                    S_WR_ACK: begin
                        if (w_scl_fall) r_sda_o <= 1'b1;
                    end
                    S_RD_DATA: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_o <= 1'b1;
                            end else begin
                                r_sda_o   <= r_tx[7];
                                r_tx      <= {r_tx[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            r_ack <= r_sda_s2;
                        end else if (w_scl_fall && !r_ack) begin
                            r_rd_idx  <= w_load_idx;
                            r_sda_o   <= w_load_byte[7];
                            r_tx      <= {w_load_byte[6:0], 1'b0};
                            r_bit_cnt <= 4'd1;
                        end
                    end
                    default: r_sda_o <= 1'b1;
                endcase
            end
        end
    end

    assign sda_o      = r_sda_o;
    assign calibrated = r_calibrated;
    assign busy       = r_busy;
    assign cmd_err    = r_cmd_err;

endmodule

// File: tb/tb_aht20_target_emulator.sv
// tb_aht20_target_emulator
// Bit-banged I2C controller driving the AHT20 target emulator. Driver tasks
// push the expected value of every response into exp_q and the observed
// value into obs_q; a monitor process pairs them up and reports.
module tb_aht20_target_emulator;
    localparam int          H    = 12;        // clocks per SCL phase
    localparam logic [31:0] MEAS = 32'd3000;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        scl_m   = 1'b1;
    logic        sda_m   = 1'b1;
    logic [19:0] hum_in  = 20'd0;
    logic [19:0] temp_in = 20'd0;
    logic        sda_o, calibrated, busy, cmd_err;
    logic        sda_bus;

    assign sda_bus = sda_m & sda_o;

    aht20_target_emulator #(.ADDRESS(7'h38), .MEAS_CYCLES(MEAS)) dut (
        .clock(clock), .reset(reset), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_o),
        .hum_in(hum_in), .temp_in(temp_in), .calibrated(calibrated), .busy(busy),
        .cmd_err(cmd_err)
    );

    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    string       exp_name_q[$];
    logic [31:0] obs_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string nm, input logic [31:0] exp_v, input logic [31:0] act_v);
        exp_q.push_back(exp_v);
        exp_name_q.push_back(nm);
        obs_q.push_back(act_v);
    endtask

    initial begin : monitor
        logic [31:0] v, e;
        string       n;
        forever begin
            @(negedge clock);
            while (obs_q.size() > 0) begin
                v = obs_q.pop_front();
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected: got %0h with nothing expected", v);
                end else begin
                    e = exp_q.pop_front();
                    n = exp_name_q.pop_front();
                    if (v !== e) begin
                        bad++;
                        $display("FAIL %s: got %0h expected %0h", n, v, e);
                    end
                end
            end
        end
    end

    // ---------------- bus/status monitors ----------------
    int   cyc = 0;
    int   err_cnt = 0;
    int   low_cnt = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   fall_cnt = 0;
    logic busy_q = 1'b0;
    logic watch = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (cmd_err) err_cnt++;
        if (watch && !sda_o) low_cnt++;
        if (busy && !busy_q) rise_cyc = cyc;
        if (!busy && busy_q) begin
            fall_cyc = cyc;
            fall_cnt++;
        end
        busy_q = busy;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic s);
        tick(H / 2); sda_m = b;
        tick(H / 2); scl_m = 1'b1;
        tick(H / 2); s = sda_bus;
        tick(H / 2); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            tick(H / 2); sda_m = 1'b1;
            tick(H / 2); scl_m = 1'b1;
        end
        tick(H / 2); sda_m = 1'b0;
        tick(H / 2); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(H / 2); sda_m = 1'b0;
        tick(H / 2); scl_m = 1'b1;
        tick(H / 2); sda_m = 1'b1;
        tick(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            v[i] = s;
        end
        send_bit(nack, s);
    endtask

    // Reads n bytes, ACKing all but the last, and checks each one.
    task automatic read_seq(input string nm, input int n, input logic [7:0] exp_b [0:8]);
        logic       ack;
        logic [7:0] v;
        i2c_start();
        write_byte(8'h71, ack);
        check({nm, " addr ack"}, 0, {31'd0, ack});
        for (int i = 0; i < n; i++) begin
            read_byte((i == n - 1) ? 1'b1 : 1'b0, v);
            check($sformatf("%s byte%0d", nm, i), {24'd0, exp_b[i]}, {24'd0, v});
        end
        i2c_stop();
    endtask

    task automatic write_seq(input string nm, input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
        logic       ack;
        logic [7:0] bytes [0:2];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        i2c_start();
        write_byte(8'h70, ack);
        check({nm, " addr ack"}, 0, {31'd0, ack});
        for (int i = 0; i < n; i++) begin
            write_byte(bytes[i], ack);
            check($sformatf("%s data%0d ack", nm, i), 0, {31'd0, ack});
        end
        i2c_stop();
    endtask

    // Reference CRC-8 (0x31, init 0xFF) computed byte by byte.
    function automatic logic [7:0] crc_model(input logic [47:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            c = c ^ d[47 - 8 * k -: 8];
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        end
        return c;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stim
        logic       ack, s;
        logic [7:0] v;
        logic [7:0] eb [0:8];
        int         e0, f0, budget;

        // Reset state.
        tick(5);
        check("reset sda_o", 1, {31'd0, sda_o});
        check("reset calibrated", 0, {31'd0, calibrated});
        check("reset busy", 0, {31'd0, busy});
        check("reset cmd_err", 0, {31'd0, cmd_err});
        reset = 1'b0;
        tick(5);

        // Address probe: ACK, no state change, no error.
        e0 = err_cnt;
        write_seq("probe", 0, 8'h00, 8'h00, 8'h00);
        tick(4);
        check("probe calibrated", 0, {31'd0, calibrated});
        check("probe busy", 0, {31'd0, busy});
        check("probe err", e0, err_cnt);

        // One-byte status read before calibration.
        eb[0] = 8'h00;
        read_seq("status0", 1, eb);

        // Wrong address: no ACK, SDA never pulled.
        watch = 1'b1;
        i2c_start();
        write_byte(8'h72, ack);
        check("0x39 addr nack", 1, {31'd0, ack});
        write_byte(8'h55, ack);
        check("0x39 data nack", 1, {31'd0, ack});
        i2c_stop();
        watch = 1'b0;
        check("0x39 sda low cycles", 0, low_cnt);

        // Calibration.
        write_seq("cal", 3, 8'hBE, 8'h08, 8'h00);
        tick(4);
        check("cal calibrated", 1, {31'd0, calibrated});
        check("cal err", e0, err_cnt);
        eb[0] = 8'h08;
        read_seq("status cal", 1, eb);

        // Measurement trigger.
        hum_in  = 20'h80000;
        temp_in = 20'h66666;
        f0 = fall_cnt;
        write_seq("trig", 3, 8'hAC, 8'h33, 8'h00);
        tick(4);
        check("trig busy", 1, {31'd0, busy});
        check("trig err", e0, err_cnt);
        // While busy: status shows busy, data bytes still the old (cleared) results.
        eb[0] = 8'h88; eb[1] = 8'h00;
        read_seq("busy read", 2, eb);
        // Second trigger while busy is silently ignored.
        write_seq("retrig", 3, 8'hAC, 8'h33, 8'h00);
        tick(4);
        check("retrig err", e0, err_cnt);
        check("retrig busy", 1, {31'd0, busy});

        budget = 0;
        while (fall_cnt == f0 && budget < 2 * int'(MEAS)) begin
            tick(1);
            budget++;
        end
        check("busy fell", 1, {31'd0, fall_cnt > f0});
        check("meas duration", MEAS + 1, fall_cyc - rise_cyc);

        // Seven-byte measurement read.
        eb[0] = 8'h08; eb[1] = 8'h80; eb[2] = 8'h00; eb[3] = 8'h06;
        eb[4] = 8'h66; eb[5] = 8'h66;
        eb[6] = crc_model({8'h08, 8'h80, 8'h00, 8'h06, 8'h66, 8'h66});
        eb[7] = 8'hFF; eb[8] = 8'hFF;
        read_seq("meas", 7, eb);

        // Unknown command.
        write_seq("badcmd", 3, 8'hAC, 8'h33, 8'h01);
        tick(4);
        check("badcmd err", e0 + 1, err_cnt);
        check("badcmd busy", 0, {31'd0, busy});

        // Write AC, repeated START, read status, STOP.
        i2c_start();
        write_byte(8'h70, ack);
        check("rs addr ack", 0, {31'd0, ack});
        write_byte(8'hAC, ack);
        check("rs data ack", 0, {31'd0, ack});
        i2c_start();
        write_byte(8'h71, ack);
        check("rs read addr ack", 0, {31'd0, ack});
        read_byte(1'b1, v);
        check("rs status", 8'h08, {24'd0, v});
        i2c_stop();
        tick(4);
        check("rs err", e0 + 2, err_cnt);
        check("rs busy", 0, {31'd0, busy});

        // Overread: bytes 7 and 8 are 0xFF.
        read_seq("overread", 9, eb);

        // Reset while byte 2 (0x00) is being driven.
        i2c_start();
        write_byte(8'h71, ack);
        check("rst addr ack", 0, {31'd0, ack});
        read_byte(1'b0, v);
        check("rst byte0", 8'h08, {24'd0, v});
        read_byte(1'b0, v);
        check("rst byte1", 8'h80, {24'd0, v});
        send_bit(1'b1, s);
        check("rst byte2 bit7", 0, {31'd0, s});
        tick(H / 2); sda_m = 1'b1;
        tick(H / 2); scl_m = 1'b1;
        tick(H / 2);
        check("rst pre sda_o", 0, {31'd0, sda_o});
        reset = 1'b1;
        tick(1);
        check("rst sda_o", 1, {31'd0, sda_o});
        check("rst calibrated", 0, {31'd0, calibrated});
        tick(2);
        reset = 1'b0;
        tick(H / 2); scl_m = 1'b0;
        i2c_stop();
        eb[0] = 8'h00; eb[1] = 8'h00;
        read_seq("post reset", 2, eb);

        tick(10);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
